// File: rtl/audio_dac.sv
// Audio output stage: resamples the 6-bit mixer sample, applies a click-free mute ramp, and drives a 4-bit noise-shaped level and a 1-bit PDM stream.
// Optional one-pole low-pass filter on the level path, enabled by defining AUDIO_DAC_FILTER_EN.
module audio_dac #(
   parameter int SAMPLE_DIV = 64,
   parameter int FILT_SHIFT = 3
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_ena4,
   input  logic [5:0] i_audio,
   input  logic       i_mute,
   output logic [3:0] o_audio_l,
   output logic [3:0] o_audio_r,
   output logic       o_pdm,
   output logic       o_muted,
   output logic       o_sample_strobe
);

   localparam int DIV_W = $clog2(SAMPLE_DIV);

   if (SAMPLE_DIV < 2 || SAMPLE_DIV > 1024) begin : g_bad_div
      $error("audio_dac: SAMPLE_DIV must be 2..1024");
   end
   if (FILT_SHIFT < 1 || FILT_SHIFT > 5) begin : g_bad_shift
      $error("audio_dac: FILT_SHIFT must be 1..5");
   end

   typedef enum logic [1:0] {S_MUTE, S_UP, S_PLAY, S_DOWN} state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic [4:0]        gain_q, gain_d;
   logic [5:0]        sample_q, sample_d;
   logic              strobe_q, strobe_d;
   logic              strobe2_q, strobe2_d;
   logic [5:0]        scaled_q, scaled_d;
   logic [1:0]        err_q, err_d;
   logic [3:0]        shp_q, shp_d;
   logic [6:0]        pdm_acc_q, pdm_acc_d;
   logic [5:0]        level;
   logic              tick;
   logic [10:0]       prod;
   logic [6:0]        shp_sum;

   assign tick = i_ena4 && (div_cnt_q == DIV_W'(SAMPLE_DIV - 1));

   // Sample capture and gain pipeline: capture on tick, scale one cycle later.
   always_comb begin
      div_cnt_d = div_cnt_q;
      if (i_ena4) begin
         div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
      end
      sample_d  = tick ? i_audio : sample_q;
      strobe_d  = tick;
      strobe2_d = strobe_q;
      prod      = {5'd0, sample_q} * {6'd0, gain_q};
      scaled_d  = strobe_q ? 6'(prod >> 4) : scaled_q;
   end

   // Gain FSM: one gain step per tick; a direction change continues from the current gain.
   always_comb begin
      state_d = state_q;
      gain_d  = gain_q;
      if (tick) begin
         case (state_q)
            S_MUTE: begin
               gain_d = 5'd0;
               if (!i_mute) begin
                  gain_d  = 5'd1;
                  state_d = S_UP;
               end
            end
            S_PLAY: begin
               gain_d = 5'd16;
               if (i_mute) begin
                  gain_d  = 5'd15;
                  state_d = S_DOWN;
               end
            end
            default: begin
               if (!i_mute) begin
                  gain_d  = (gain_q >= 5'd16) ? 5'd16 : gain_q + 5'd1;
                  state_d = (gain_d == 5'd16) ? S_PLAY : S_UP;
               end else begin
                  gain_d  = (gain_q == 5'd0) ? 5'd0 : gain_q - 5'd1;
                  state_d = (gain_d == 5'd0) ? S_MUTE : S_DOWN;
               end
            end
         endcase
      end
   end

   // Noise shaper keeps the 2 dropped LSBs as error; PDM is the carry of a 6-bit accumulator.
   always_comb begin
      shp_sum   = {1'b0, level} + {5'd0, err_q};
      shp_d     = shp_q;
      err_d     = err_q;
      if (i_ena4) begin
         shp_d = shp_sum[6] ? 4'hF : shp_sum[5:2];
         err_d = shp_sum[1:0];
      end
      pdm_acc_d = {1'b0, pdm_acc_q[5:0]} + {1'b0, level};
   end

`ifdef AUDIO_DAC_FILTER_EN
   logic [11:0]        acc_q, acc_d;
   logic signed [12:0] diff;

   always_comb begin
      diff  = $signed({1'b0, scaled_q, 6'd0}) - $signed({1'b0, acc_q});
      acc_d = strobe2_q ? acc_q + 12'(diff >>> FILT_SHIFT) : acc_q;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign level = acc_q[11:6];
`else
   logic [5:0] level_q, level_d;

   always_comb begin
      level_d = strobe2_q ? scaled_q : level_q;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         level_q <= '0;
      end else begin
         level_q <= level_d;
      end
   end

   assign level = level_q;
`endif

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= S_MUTE;
         div_cnt_q <= '0;
         gain_q    <= '0;
         sample_q  <= '0;
         strobe_q  <= 1'b0;
         strobe2_q <= 1'b0;
         scaled_q  <= '0;
         err_q     <= '0;
         shp_q     <= '0;
         pdm_acc_q <= '0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         gain_q    <= gain_d;
         sample_q  <= sample_d;
         strobe_q  <= strobe_d;
         strobe2_q <= strobe2_d;
         scaled_q  <= scaled_d;
         err_q     <= err_d;
         shp_q     <= shp_d;
         pdm_acc_q <= pdm_acc_d;
      end
   end

   assign o_audio_l       = shp_q;
   assign o_audio_r       = shp_q;
   assign o_pdm           = pdm_acc_q[6];
   assign o_muted         = (state_q == S_MUTE);
   assign o_sample_strobe = strobe_q;

endmodule

// File: tb/tb_audio_dac.sv
// Self-checking bench for audio_dac (default build, filter disabled).
module tb_audio_dac;

   logic       clk = 1'b0;
   logic       i_reset_n = 1'b0;
   logic       i_ena4 = 1'b0;
   logic [5:0] i_audio = 6'd0;
   logic       i_mute = 1'b0;
   logic [3:0] o_audio_l, o_audio_r;
   logic       o_pdm, o_muted, o_sample_strobe;

   bit ena_run = 1'b0;
   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   audio_dac #(.SAMPLE_DIV(8), .FILT_SHIFT(3)) dut (
      .i_clk(clk),
      .i_reset_n(i_reset_n),
      .i_ena4(i_ena4),
      .i_audio(i_audio),
      .i_mute(i_mute),
      .o_audio_l(o_audio_l),
      .o_audio_r(o_audio_r),
      .o_pdm(o_pdm),
      .o_muted(o_muted),
      .o_sample_strobe(o_sample_strobe)
   );

   // i_ena4 pulses every other clock while ena_run is set
   initial begin : ena_gen
      forever begin
         @(negedge clk);
         if (ena_run) i_ena4 = ~i_ena4;
         else         i_ena4 = 1'b0;
      end
   end

   typedef struct {
      logic [5:0] audio;
      int         exp_sum4;
      int         exp_ones;
   } vec_t;

   vec_t tab[8];

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
      else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   task automatic wait_strobe(input string name);
      bit got = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (o_sample_strobe) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         compared++;
         mismatched++;
         $display("FAIL %s: no sample strobe within 400 cycles, expected one", name);
      end
      repeat (4) @(negedge clk);
   endtask

   // Freeze i_ena4 so no new sample lands, then count PDM ones over 64 clocks
   task automatic pdm_count(output int n);
      ena_run = 1'b0;
      repeat (2) @(negedge clk);
      n = 0;
      repeat (64) begin
         @(negedge clk);
         n += int'(o_pdm);
      end
      ena_run = 1'b1;
   endtask

   // Sum of the next four shaper outputs (one per i_ena4 pulse)
   task automatic shaper_sum4(output int s);
      int w;
      s = 0;
      for (int k = 0; k < 4; k++) begin
         w = 0;
         do begin
            @(posedge clk);
            w++;
         end while (!i_ena4 && w < 20);
         #1;
         s += int'(o_audio_l);
      end
   endtask

   initial begin : main
      int n;
      int s;
      int pulses;
      bit found;

      // audio, sum of 4 shaper outputs, PDM ones per 64 clocks
      tab[0] = '{6'd0,  0,  0};
      tab[1] = '{6'd1,  1,  1};
      tab[2] = '{6'd17, 17, 17};
      tab[3] = '{6'd32, 32, 32};
      tab[4] = '{6'd45, 45, 45};
      tab[5] = '{6'd60, 60, 60};
      tab[6] = '{6'd61, 60, 61};
      tab[7] = '{6'd63, 60, 63};

      // Reset held while inputs are active
      i_audio = 6'd63;
      i_mute = 1'b0;
      ena_run = 1'b1;
      repeat (20) @(negedge clk);
      check("reset o_audio_l", int'(o_audio_l), 0);
      check("reset o_audio_r", int'(o_audio_r), 0);
      check("reset o_pdm", int'(o_pdm), 0);
      check("reset o_sample_strobe", int'(o_sample_strobe), 0);
      check("reset o_muted", int'(o_muted), 1);

      // Ramp up from silence with audio=60: level after strobe k is (60*k)>>4
      i_audio = 6'd60;
      i_reset_n = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         wait_strobe($sformatf("ramp strobe %0d", k));
         if (k == 1) check("o_muted after first tick", int'(o_muted), 0);
         pdm_count(n);
         check($sformatf("ramp up level k=%0d", k), n, (60 * k) >> 4);
      end

      // Steady-state levels at unity gain
      for (int i = 0; i < 8; i++) begin
         i_audio = tab[i].audio;
         wait_strobe($sformatf("table %0d strobe", i));
         shaper_sum4(s);
         check($sformatf("shaper sum4 audio=%0d", tab[i].audio), s, tab[i].exp_sum4);
         check($sformatf("o_audio_r==o_audio_l audio=%0d", tab[i].audio),
               int'(o_audio_r), int'(o_audio_l));
         pdm_count(n);
         check($sformatf("pdm ones audio=%0d", tab[i].audio), n, tab[i].exp_ones);
      end

      // Ramp reversal at audio=63: down 5 ticks (gain 15..11), then up 5 (12..16)
      i_mute = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         wait_strobe($sformatf("rev down %0d", k));
         pdm_count(n);
         check($sformatf("rev down gain=%0d", 16 - k), n, (63 * (16 - k)) >> 4);
      end
      i_mute = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         wait_strobe($sformatf("rev up %0d", k));
         pdm_count(n);
         check($sformatf("rev up gain=%0d", 11 + k), n, (63 * (11 + k)) >> 4);
         check($sformatf("rev up o_muted %0d", k), int'(o_muted), 0);
      end

      // Full mute from play: muted after exactly 16 ticks
      i_mute = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         wait_strobe($sformatf("mute strobe %0d", k));
         if (k == 15) begin
            check("o_muted after 15 ticks", int'(o_muted), 0);
            pdm_count(n);
            check("level after 15 mute ticks", n, 3);
         end
      end
      check("o_muted after 16 ticks", int'(o_muted), 1);
      pdm_count(n);
      check("pdm ones when muted", n, 0);
      shaper_sum4(s);
      check("shaper sum4 when muted", s, 0);

      // i_ena4 held low: no samples are taken
      ena_run = 1'b0;
      n = 0;
      repeat (200) begin
         @(negedge clk);
         n += int'(o_sample_strobe);
      end
      check("strobes with i_ena4 low", n, 0);
      ena_run = 1'b1;

      // Async reset mid-operation, then restart from div_cnt=0
      i_mute = 1'b0;
      repeat (3) wait_strobe("pre-reset strobe");
      shaper_sum4(s);
      check("shaper sum4 before reset (gain 3, level 11)", s, 11);
      @(posedge clk);
      #2 i_reset_n = 1'b0;
      #1;
      check("async reset o_audio_l", int'(o_audio_l), 0);
      check("async reset o_pdm", int'(o_pdm), 0);
      check("async reset o_muted", int'(o_muted), 1);
      repeat (3) @(negedge clk);
      i_reset_n = 1'b1;
      pulses = 0;
      found = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         if (i_ena4) pulses++;
         #1;
         if (o_sample_strobe) begin
            found = 1'b1;
            break;
         end
      end
      check("strobe seen after reset release", int'(found), 1);
      check("i_ena4 pulses to first tick", pulses, 8);
      @(posedge clk);
      #1;
      check("strobe is one cycle", int'(o_sample_strobe), 0);
      repeat (4) @(negedge clk);
      pdm_count(n);
      check("level after first tick post-reset", n, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
